// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
//
// Instruction memory for the fetch stage of the MIPS pipeline, loaded over a
// byte stream. A debug/UART source pushes program bytes (most-significant byte
// of each word first) while the block is in LOAD. The fetch stage later reads
// words by byte-addressed PC while the block is in RUN.
//
// Mode machine:
//   IDLE -> LOAD on i_load_start
//   LOAD -> LOAD on i_load_start (restart)
//   LOAD -> RUN  when HALT_WORD is written or the memory becomes full
//   RUN  -> LOAD on i_load_start
//
// Ports:
//   i_clk, i_reset_n  clock (rising edge) and asynchronous active-low reset
//   i_load_start      pulse: enter LOAD and clear the loaded program
//   i_byte_valid      i_byte carries a program byte this cycle
//   i_byte            program byte, MSB of the word first
//   o_byte_ready      high while in LOAD
//   i_fetch_en        fetch enable; low stalls (holds the output)
//   i_flush           replace the fetched instruction with a NOP
//   i_PC              byte address of the instruction to fetch
//   o_Instruction     registered instruction word (1-cycle latency)
//   o_valid           o_Instruction holds a fetched word (or in-range NOP)
//   o_load_done       one-cycle pulse when a load completes
//   o_words_loaded    number of words written by the current load
//   o_addr_error      sticky: misaligned or out-of-range PC seen in RUN
//   o_mode            00 IDLE, 01 LOAD, 10 RUN
// ----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int unsigned      NBITS     = 32,
   parameter int unsigned      DEPTH     = 64,
   parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
   input  logic                           i_clk,
   input  logic                           i_reset_n,
   input  logic                           i_load_start,
   input  logic                           i_byte_valid,
   input  logic [7:0]                     i_byte,
   output logic                           o_byte_ready,
   input  logic                           i_fetch_en,
   input  logic                           i_flush,
   input  logic [NBITS-1:0]               i_PC,
   output logic [NBITS-1:0]               o_Instruction,
   output logic                           o_valid,
   output logic                           o_load_done,
   output logic [$clog2(DEPTH+1)-1:0]     o_words_loaded,
   output logic                           o_addr_error,
   output logic [1:0]                     o_mode
);

   localparam int unsigned BPW    = NBITS / 8;
   localparam int unsigned BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   localparam logic [NBITS-1:0]  BPW_N     = NBITS'(BPW);
   localparam logic [NBITS-1:0]  DEPTH_N   = NBITS'(DEPTH);
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BPW - 1);
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   // Program storage; deliberately not reset. Stale contents are masked by
   // words_q, so a fetch beyond the loaded range returns a NOP instead.
   logic [NBITS-1:0] mem [DEPTH];

   state_t              state_q,    state_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [NBITS-1:0]    asm_q,      asm_d;
   logic [CNT_W-1:0]    words_q,    words_d;
   logic [NBITS-1:0]    instr_q,    instr_d;
   logic                valid_q,    valid_d;
   logic                done_q,     done_d;
   logic                err_q,      err_d;

   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;
   logic [NBITS-1:0]    wr_data;

   logic [NBITS-1:0]    asm_shift;
   logic                last_byte;
   logic [NBITS-1:0]    fetch_idx;
   logic                fetch_misal;
   logic                fetch_oor;
   logic                fetch_unwr;
   logic [NBITS-1:0]    rd_word;

   // Byte assembler: the incoming byte enters at the bottom so the first byte
   // of a word ends up in the top byte once the word is complete.
   assign asm_shift = (asm_q << 8) | NBITS'(i_byte);
   assign last_byte = (byte_cnt_q == LAST_BYTE);

   // Fetch address decode. The whole PC is compared, so upper bits beyond the
   // index range flag an error instead of wrapping into the array.
   assign fetch_idx   = i_PC / BPW_N;
   assign fetch_misal = ((i_PC % BPW_N) != '0);
   assign fetch_oor   = (fetch_idx >= DEPTH_N);
   assign fetch_unwr  = (fetch_idx >= NBITS'(words_q));
   assign rd_word     = mem[fetch_idx[IDX_W-1:0]];

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      words_d    = words_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_en      = 1'b0;
      wr_idx     = words_q[IDX_W-1:0];
      wr_data    = asm_shift;

      if (i_load_start) begin
         // Start (or restart) a load from any mode; a same-cycle byte is lost.
         state_d    = ST_LOAD;
         byte_cnt_d = '0;
         asm_d      = '0;
         words_d    = '0;
         instr_d    = '0;
         valid_d    = 1'b0;
         err_d      = 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (i_byte_valid) begin
                  asm_d = asm_shift;
                  if (last_byte) begin
                     // Word complete: write it at the pointer on this edge.
                     byte_cnt_d = '0;
                     wr_en      = 1'b1;
                     words_d    = words_q + 1'b1;
                     if ((asm_shift == HALT_WORD) || (words_q == LAST_WORD)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                     end
                  end else begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (i_flush) begin
                  instr_d = '0;
                  valid_d = 1'b0;
               end else if (i_fetch_en) begin
                  if (fetch_misal || fetch_oor) begin
                     instr_d = '0;
                     valid_d = 1'b0;
                     err_d   = 1'b1;
                  end else if (fetch_unwr) begin
                     instr_d = '0;
                     valid_d = 1'b1;
                  end else begin
                     instr_d = rd_word;
                     valid_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         words_q    <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         words_q    <= words_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign o_byte_ready   = (state_q == ST_LOAD);
   assign o_Instruction  = instr_q;
   assign o_valid        = valid_q;
   assign o_load_done    = done_q;
   assign o_words_loaded = words_q;
   assign o_addr_error   = err_q;
   assign o_mode         = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic        i_load_start;
   logic        i_byte_valid;
   logic [7:0]  i_byte;
   logic        o_byte_ready;
   logic        i_fetch_en;
   logic        i_flush;
   logic [31:0] i_PC;
   logic [31:0] o_Instruction;
   logic        o_valid;
   logic        o_load_done;
   logic [2:0]  o_words_loaded;
   logic        o_addr_error;
   logic [1:0]  o_mode;

   always #5 clk = ~clk;

   instr_mem_loader #(.NBITS(32), .DEPTH(DEPTH), .HALT_WORD(32'hFFFFFFFF)) dut (
      .i_clk          (clk),
      .i_reset_n      (i_reset_n),
      .i_load_start   (i_load_start),
      .i_byte_valid   (i_byte_valid),
      .i_byte         (i_byte),
      .o_byte_ready   (o_byte_ready),
      .i_fetch_en     (i_fetch_en),
      .i_flush        (i_flush),
      .i_PC           (i_PC),
      .o_Instruction  (o_Instruction),
      .o_valid        (o_valid),
      .o_load_done    (o_load_done),
      .o_words_loaded (o_words_loaded),
      .o_addr_error   (o_addr_error),
      .o_mode         (o_mode)
   );

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   vecs = 0;
   int   miss = 0;

   // Reference model state
   logic [31:0] m_mem [DEPTH];
   int          m_cnt;
   int          m_bc;
   logic [31:0] m_asm;
   logic [1:0]  m_mode;
   logic [31:0] m_instr;
   logic        m_valid;
   logic        m_err;
   logic        m_done;

   task automatic model_clear();
      m_cnt = 0; m_bc = 0; m_asm = '0;
      m_instr = '0; m_valid = 1'b0; m_err = 1'b0; m_done = 1'b0;
   endtask

   task automatic idle_cycle();
      m_done = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_start(input logic with_byte, input logic [7:0] b);
      i_load_start = 1'b1; i_byte_valid = with_byte; i_byte = b;
      model_clear();
      m_mode = 2'b01;
      @(posedge clk); #1;
      i_load_start = 1'b0; i_byte_valid = 1'b0; i_byte = '0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_byte_valid = 1'b1; i_byte = b;
      m_done = 1'b0;
      if (m_mode == 2'b01) begin
         m_asm = {m_asm[23:0], b};
         m_bc++;
         if (m_bc == 4) begin
            m_bc = 0;
            m_mem[m_cnt] = m_asm;
            m_cnt++;
            if (m_asm == 32'hFFFFFFFF || m_cnt == DEPTH) begin
               m_mode = 2'b10;
               m_done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      i_byte_valid = 1'b0; i_byte = '0;
   endtask

   // Drives one fetch-side cycle and pushes the expected registered output.
   task automatic drive_fetch(input logic [31:0] pc, input logic en, input logic flush);
      exp_t e;
      m_done = 1'b0;
      if (m_mode == 2'b10) begin
         if (flush) begin
            m_instr = '0; m_valid = 1'b0;
         end else if (en) begin
            if ((pc % 4) != 0 || (pc / 4) >= DEPTH) begin
               m_instr = '0; m_valid = 1'b0; m_err = 1'b1;
            end else if ((pc / 4) >= m_cnt) begin
               m_instr = '0; m_valid = 1'b1;
            end else begin
               m_instr = m_mem[pc / 4]; m_valid = 1'b1;
            end
         end
      end
      e.instr = m_instr; e.valid = m_valid; e.err = m_err;
      exp_q.push_back(e);
      i_fetch_en = en; i_flush = flush; i_PC = pc;
      @(posedge clk); #1;
      i_fetch_en = 1'b0; i_flush = 1'b0;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      m_mode = 2'b00;
      model_clear();
      #12;
      vecs++;
      if ({o_mode, o_byte_ready, o_load_done, o_valid, o_addr_error} !== 6'b0) begin
         miss++;
         $display("FAIL reset_ctrl: mode=%b rdy=%b done=%b valid=%b err=%b, want all 0",
                  o_mode, o_byte_ready, o_load_done, o_valid, o_addr_error);
      end
      vecs++;
      if (o_Instruction !== 32'h0 || o_words_loaded !== 3'd0) begin
         miss++;
         $display("FAIL reset_data: instr=%h words=%0d, want 0/0", o_Instruction, o_words_loaded);
      end
      @(negedge clk); i_reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load_program();
      logic [7:0] prog [12];
      prog = '{8'h00, 8'h24, 8'h00, 8'h04, 8'h00, 8'h01, 8'hF0, 8'h21,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
      pulse_start(1'b0, 8'h00);
      vecs++;
      if (o_mode !== 2'b01 || o_byte_ready !== 1'b1) begin
         miss++;
         $display("FAIL load_enter: mode=%b rdy=%b, want 01/1", o_mode, o_byte_ready);
      end
      for (int i = 0; i < 12; i++) begin
         send_byte(prog[i]);
         vecs++;
         if (o_words_loaded !== 3'(m_cnt) || o_mode !== m_mode || o_load_done !== m_done) begin
            miss++;
            $display("FAIL load_byte%0d: words=%0d mode=%b done=%b, want %0d/%b/%b",
                     i, o_words_loaded, o_mode, o_load_done, m_cnt, m_mode, m_done);
         end
      end
      vecs++;
      if (o_words_loaded !== 3'd3 || o_mode !== 2'b10 || o_load_done !== 1'b1) begin
         miss++;
         $display("FAIL load_end: words=%0d mode=%b done=%b, want 3/10/1",
                  o_words_loaded, o_mode, o_load_done);
      end
      idle_cycle();
      vecs++;
      if (o_load_done !== 1'b0) begin
         miss++;
         $display("FAIL done_pulse: done=%b, want 0", o_load_done);
      end
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         drive_fetch(32'(i * 4), 1'b1, 1'b0);
         e = exp_q.pop_front();
         vecs++;
         if (o_Instruction !== e.instr || o_valid !== e.valid || o_addr_error !== e.err) begin
            miss++;
            $display("FAIL fetch_prog pc=%0d: instr=%h v=%b e=%b, want %h/%b/%b",
                     i * 4, o_Instruction, o_valid, o_addr_error, e.instr, e.valid, e.err);
         end
      end
      vecs++;
      if (m_mem[1] !== 32'h0001F021) begin
         miss++;
         $display("FAIL model_word1: %h, want 0001f021", m_mem[1]);
      end
   endtask

   task automatic test_fetch_errors();
      logic [31:0] pcs [5];
      pcs = '{32'd12, 32'd6, 32'd0, 32'h0001_0000, 32'd4};
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         drive_fetch(pcs[i], 1'b1, 1'b0);
         e = exp_q.pop_front();
         vecs++;
         if (o_Instruction !== e.instr || o_valid !== e.valid || o_addr_error !== e.err) begin
            miss++;
            $display("FAIL fetch_err pc=%h: instr=%h v=%b e=%b, want %h/%b/%b",
                     pcs[i], o_Instruction, o_valid, o_addr_error, e.instr, e.valid, e.err);
         end
      end
      pulse_start(1'b0, 8'h00);
      vecs++;
      if (o_addr_error !== 1'b0 || o_words_loaded !== 3'd0 || o_valid !== 1'b0) begin
         miss++;
         $display("FAIL err_clear: err=%b words=%0d valid=%b, want 0/0/0",
                  o_addr_error, o_words_loaded, o_valid);
      end
   endtask

   task automatic test_full();
      for (int i = 1; i <= 16; i++) send_byte(8'(i));
      vecs++;
      if (o_mode !== 2'b10 || o_words_loaded !== 3'd4 || o_load_done !== 1'b1) begin
         miss++;
         $display("FAIL full_end: mode=%b words=%0d done=%b, want 10/4/1",
                  o_mode, o_words_loaded, o_load_done);
      end
      for (int i = 0; i < 4; i++) send_byte(8'hA5);
      vecs++;
      if (o_mode !== 2'b10 || o_words_loaded !== 3'd4 || o_load_done !== 1'b0) begin
         miss++;
         $display("FAIL full_extra: mode=%b words=%0d done=%b, want 10/4/0",
                  o_mode, o_words_loaded, o_load_done);
      end
      for (int i = 3; i <= 4; i++) begin
         exp_t e;
         drive_fetch(32'(i * 4), 1'b1, 1'b0);
         e = exp_q.pop_front();
         vecs++;
         if (o_Instruction !== e.instr || o_valid !== e.valid || o_addr_error !== e.err) begin
            miss++;
            $display("FAIL fetch_full pc=%0d: instr=%h v=%b e=%b, want %h/%b/%b",
                     i * 4, o_Instruction, o_valid, o_addr_error, e.instr, e.valid, e.err);
         end
      end
   endtask

   task automatic test_stall_flush();
      logic [31:0] pcs [5];
      logic        ens [5];
      logic        fls [5];
      pcs = '{32'd4, 32'd8, 32'd12, 32'd0, 32'd8};
      ens = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      fls = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         drive_fetch(pcs[i], ens[i], fls[i]);
         e = exp_q.pop_front();
         vecs++;
         if (o_Instruction !== e.instr || o_valid !== e.valid) begin
            miss++;
            $display("FAIL stall_flush step%0d: instr=%h v=%b, want %h/%b",
                     i, o_Instruction, o_valid, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_reset_midload();
      pulse_start(1'b0, 8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      #2 i_reset_n = 1'b0;
      m_mode = 2'b00;
      model_clear();
      #1;
      vecs++;
      if ({o_mode, o_byte_ready, o_load_done, o_valid, o_addr_error} !== 6'b0 ||
          o_Instruction !== 32'h0 || o_words_loaded !== 3'd0) begin
         miss++;
         $display("FAIL midload_reset: mode=%b rdy=%b words=%0d instr=%h, want all 0",
                  o_mode, o_byte_ready, o_words_loaded, o_Instruction);
      end
      @(negedge clk); i_reset_n = 1'b1;
      @(posedge clk); #1;
      pulse_start(1'b0, 8'h00);
      for (int i = 0; i < 4; i++) send_byte(8'hFF);
      vecs++;
      if (o_words_loaded !== 3'd1 || o_mode !== 2'b10) begin
         miss++;
         $display("FAIL reload_halt: words=%0d mode=%b, want 1/10", o_words_loaded, o_mode);
      end
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         drive_fetch(32'(i * 4), 1'b1, 1'b0);
         e = exp_q.pop_front();
         vecs++;
         if (o_Instruction !== e.instr || o_valid !== e.valid || o_addr_error !== e.err) begin
            miss++;
            $display("FAIL fetch_reload pc=%0d: instr=%h v=%b e=%b, want %h/%b/%b",
                     i * 4, o_Instruction, o_valid, o_addr_error, e.instr, e.valid, e.err);
         end
      end
   endtask

   task automatic test_start_drops_byte();
      logic [7:0] bytes [8];
      bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      pulse_start(1'b0, 8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      pulse_start(1'b1, 8'hCC);
      vecs++;
      if (o_mode !== 2'b01 || o_words_loaded !== 3'd0) begin
         miss++;
         $display("FAIL start_byte: mode=%b words=%0d, want 01/0", o_mode, o_words_loaded);
      end
      for (int i = 0; i < 8; i++) send_byte(bytes[i]);
      vecs++;
      if (o_words_loaded !== 3'd2 || o_mode !== 2'b10) begin
         miss++;
         $display("FAIL start_load: words=%0d mode=%b, want 2/10", o_words_loaded, o_mode);
      end
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         drive_fetch(32'(i * 4), 1'b1, 1'b0);
         e = exp_q.pop_front();
         vecs++;
         if (o_Instruction !== e.instr || o_valid !== e.valid) begin
            miss++;
            $display("FAIL fetch_drop pc=%0d: instr=%h v=%b, want %h/%b",
                     i * 4, o_Instruction, o_valid, e.instr, e.valid);
         end
      end
      vecs++;
      if (m_mem[0] !== 32'h12345678) begin
         miss++;
         $display("FAIL model_word0: %h, want 12345678", m_mem[0]);
      end
   endtask

   initial begin
      i_reset_n = 1'b0; i_load_start = 1'b0; i_byte_valid = 1'b0; i_byte = '0;
      i_fetch_en = 1'b0; i_flush = 1'b0; i_PC = '0;
      test_reset();
      test_load_program();
      test_fetch_errors();
      test_full();
      test_stall_flush();
      test_reset_midload();
      test_start_drops_byte();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
